// File: rtl/pci_bridge_pkg.sv
// pci_bridge_pkg: shared PCI bridge constants, subspace/state types and decode helpers
package pci_bridge_pkg;
  localparam logic [2:0] WIN_DEFAULT = 3'b101;
  localparam logic [3:0] CMD_IO_RD = 4'b0010;
  localparam logic [3:0] CMD_IO_WR = 4'b0011;
  localparam logic [3:0] CMD_MEM_RD = 4'b0110;
  localparam logic [3:0] CMD_MEM_WR = 4'b0111;
  localparam logic [3:0] CMD_CFG_RD = 4'b1010;
  localparam logic [3:0] CMD_CFG_WR = 4'b1011;
  localparam logic [3:0] CMD_MEM_RD_LINE = 4'b1110;
  typedef enum logic [1:0] {SUB_MEM, SUB_IO, SUB_CFG, SUB_REG} subspace_t;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  // Active-low lanes; bit n is address offset n because lanes are byte-swapped downstream.
  function automatic logic [3:0] byte_enables(input logic [1:0] siz, input logic [1:0] a);
    return siz == 2'b01 ? ~(4'b0001 << a) : siz == 2'b10 ? (a[1] ? 4'b0011 : 4'b1100) : 4'b0000;
  endfunction
  function automatic logic [3:0] pci_cmd(input subspace_t sub, input logic rnw, input logic line);
    return sub == SUB_IO ? (rnw ? CMD_IO_RD : CMD_IO_WR) :
           sub == SUB_CFG ? (rnw ? CMD_CFG_RD : CMD_CFG_WR) :
           rnw ? (line ? CMD_MEM_RD_LINE : CMD_MEM_RD) : CMD_MEM_WR;
  endfunction
endpackage

// File: rtl/toggle_sync.sv
// toggle_sync: 2-flop synchroniser for a toggle signal plus single-cycle edge detect
module toggle_sync (
  input  logic clk,
  input  logic nRESET,
  input  logic tog,
  output logic pulse
);
  logic [2:0] sr;
  // Stages 0/1 synchronise, stage 2 remembers the last seen level.
  always_ff @(posedge clk or negedge nRESET)
    if (!nRESET) sr <= '0;
    else sr <= {sr[1:0], tog};
  assign pulse = sr[1] ^ sr[2];
endmodule

// File: rtl/pci_cpu_cycle_ctrl.sv
// pci_cpu_cycle_ctrl: 68040-side PCI window decode, request handshake, beat/ack tracking and timeout
module pci_cpu_cycle_ctrl
  import pci_bridge_pkg::*;
#(
  parameter logic [2:0] WIN = WIN_DEFAULT,
  parameter int TIMEOUT = 255
) (
  input  logic        BCLK,
  input  logic        nRESET,
  input  logic        nTS,
  input  logic        TT0,
  input  logic        TT1,
  input  logic        RnW,
  input  logic [1:0]  SIZ,
  input  logic [31:0] A,
  input  logic        nBG,
  input  logic        nTA,
  input  logic        ACK_TOG,
  input  logic        PCI_ERR,
  output logic        PCICYCLE,
  output logic        nBEN,
  output logic        REQ_TOG,
  output logic [3:0]  CMD,
  output logic [3:0]  nCBE,
  output logic [31:0] PADDR,
  output logic        BURST,
  output logic        nTEA
);
  state_t state, state_n;
  subspace_t sub;
  logic [2:0] beats, beats_n;
  logic [7:0] tcnt;
  logic ack_edge, ack_seen, reg_cyc, hit, launch, reg_start, ok, tea;
  toggle_sync u_ack_sync (.clk(BCLK), .nRESET(nRESET), .tog(ACK_TOG), .pulse(ack_edge));
  assign sub = subspace_t'(A[28:27]);
  assign hit = !nTS && !nBG && A[31:29] == WIN;
  assign launch = state == IDLE && hit && sub != SUB_REG && !reg_cyc;
  assign reg_start = state == IDLE && hit && sub == SUB_REG && !reg_cyc;
  assign beats_n = (!nTA && beats != 3'd4) ? beats + 3'd1 : beats;
  assign ok = (ack_edge || ack_seen) && beats_n >= (BURST ? 3'd4 : 3'd1);
  // Next state; an ack on the timeout edge suppresses the timeout.
  always_comb begin
    state_n = state;
    tea = 1'b0;
    case (state)
      IDLE: state_n = launch ? REQ : IDLE;
      REQ:  state_n = WAIT;
      WAIT: begin
        tea = (ack_edge && PCI_ERR) || (!ack_edge && !ok && tcnt == 8'(TIMEOUT - 1));
        state_n = (tea || ok) ? DONE : WAIT;
      end
      default: state_n = IDLE;
    endcase
  end
  // State register.
  always_ff @(posedge BCLK or negedge nRESET)
    if (!nRESET) state <= IDLE;
    else state <= state_n;
  // Cycle outputs, latched transfer attributes and WAIT bookkeeping.
  always_ff @(posedge BCLK or negedge nRESET)
    if (!nRESET) begin
      PCICYCLE <= 1'b0;
      nBEN <= 1'b1;
      REQ_TOG <= 1'b0;
      CMD <= 4'h0;
      nCBE <= 4'hF;
      PADDR <= '0;
      BURST <= 1'b0;
      nTEA <= 1'b1;
      beats <= '0;
      tcnt <= '0;
      ack_seen <= 1'b0;
      reg_cyc <= 1'b0;
    end else begin
      if (launch) begin
        PCICYCLE <= 1'b1;
        nBEN <= 1'b0;
        CMD <= pci_cmd(sub, RnW, TT0 && !TT1);
        nCBE <= byte_enables(SIZ, A[1:0]);
        PADDR <= sub == SUB_MEM ? {A[31:2], 2'b00} : A;
        BURST <= TT0 && !TT1;
      end
      if (reg_start) begin
        reg_cyc <= 1'b1;
        nBEN <= 1'b0;
      end
      if (reg_cyc && !nTA) begin
        reg_cyc <= 1'b0;
        nBEN <= 1'b1;
      end
      if (state == REQ) begin
        REQ_TOG <= ~REQ_TOG;
        tcnt <= '0;
        beats <= '0;
        ack_seen <= 1'b0;
      end
      if (state == WAIT) begin
        beats <= beats_n;
        ack_seen <= ack_seen || ack_edge;
        tcnt <= tcnt == 8'(TIMEOUT - 1) ? tcnt : tcnt + 8'd1;
      end
      nTEA <= !tea;
      if (state == DONE) begin
        PCICYCLE <= 1'b0;
        nBEN <= 1'b1;
        CMD <= 4'h0;
        nCBE <= 4'hF;
        PADDR <= '0;
        BURST <= 1'b0;
      end
    end
endmodule

// File: tb/tb_pci_cpu_cycle_ctrl.sv
// tb_pci_cpu_cycle_ctrl: directed and random transfers checked against a cycle-timeline reference model
module tb_pci_cpu_cycle_ctrl;
  localparam int TMO = 255;
  logic BCLK = 1'b0, nRESET, nTS, TT0, TT1, RnW, nBG, nTA, ACK_TOG, PCI_ERR;
  logic [1:0] SIZ;
  logic [31:0] A;
  logic PCICYCLE, nBEN, REQ_TOG, BURST, nTEA;
  logic [3:0] CMD, nCBE;
  logic [31:0] PADDR;
  int n_chk = 0, n_fail = 0;
  logic exp_req = 1'b0;

  pci_cpu_cycle_ctrl dut (
    .BCLK(BCLK), .nRESET(nRESET), .nTS(nTS), .TT0(TT0), .TT1(TT1), .RnW(RnW), .SIZ(SIZ), .A(A),
    .nBG(nBG), .nTA(nTA), .ACK_TOG(ACK_TOG), .PCI_ERR(PCI_ERR), .PCICYCLE(PCICYCLE), .nBEN(nBEN),
    .REQ_TOG(REQ_TOG), .CMD(CMD), .nCBE(nCBE), .PADDR(PADDR), .BURST(BURST), .nTEA(nTEA)
  );

  always #5 BCLK = ~BCLK;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc %0d: observed %h expected %h", tag, k, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_cmd(input logic [31:0] a, input logic rnw, input logic line);
    int s;
    s = int'(a[28:27]);
    if (s == 1) return rnw ? 4'd2 : 4'd3;
    if (s == 2) return rnw ? 4'd10 : 4'd11;
    return rnw ? (line ? 4'd14 : 4'd6) : 4'd7;
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] siz, input logic [31:0] a);
    int off;
    off = int'(a[1:0]);
    if (siz == 2'b01) return 4'(15 - (1 << off));
    if (siz == 2'b10) return off >= 2 ? 4'd3 : 4'd12;
    return 4'd0;
  endfunction

  // Edge 0 samples the hit; beats count from edge 2; an ACK_TOG flip first sampled at edge ack_at is acted on at ack_at+2.
  task automatic run_xfer(input logic [31:0] a, input logic [1:0] siz, input logic rnw,
                          input logic [63:0] mask, input int ack_at, input logic err);
    logic line, tea, act, req0;
    int tgt, got, beat_edge, det, c;
    logic [3:0] ecmd, ebe;
    logic [31:0] eaddr;
    line = siz == 2'b11;
    tgt = line ? 4 : 1;
    got = 0;
    beat_edge = -1;
    for (int k = 2; k < 64; k++)
      if (mask[k]) begin
        got++;
        if (got == tgt) beat_edge = k;
      end
    det = ack_at < 0 ? -1 : ack_at + 2;
    if (det < 0 || (beat_edge < 0 && !err)) begin
      c = 1 + TMO;
      tea = 1'b1;
    end else if (err) begin
      c = det;
      tea = 1'b1;
    end else begin
      c = det > beat_edge ? det : beat_edge;
      tea = 1'b0;
    end
    ecmd = ref_cmd(a, rnw, line);
    ebe = ref_be(siz, a);
    eaddr = a[28:27] == 2'b00 ? a & ~32'd3 : a;
    req0 = exp_req;
    @(negedge BCLK);
    nTS = 1'b0; A = a; SIZ = siz; RnW = rnw; TT0 = line; TT1 = 1'b0; nTA = 1'b1;
    for (int k = 0; k <= c + 2; k++) begin
      @(posedge BCLK);
      @(negedge BCLK);
      nTS = 1'b1;
      act = k <= c;
      chk("PCICYCLE", k, PCICYCLE, act);
      chk("nBEN", k, nBEN, !act);
      chk("nTEA", k, nTEA, !(tea && k == c));
      chk("REQ_TOG", k, REQ_TOG, k >= 1 ? !req0 : req0);
      chk("CMD", k, CMD, act ? ecmd : 4'h0);
      chk("nCBE", k, nCBE, act ? ebe : 4'hF);
      chk("PADDR", k, PADDR, act ? eaddr : 32'h0);
      chk("BURST", k, BURST, act && line);
      nTA = !(k + 1 < 64 && mask[k + 1]);
      if (k + 1 == ack_at) begin
        ACK_TOG = !ACK_TOG;
        PCI_ERR = err;
      end
    end
    nTA = 1'b1;
    PCI_ERR = 1'b0;
    exp_req = !req0;
  endtask

  initial begin
    logic [63:0] m;
    logic [1:0] sub, siz;
    int e, tgt;
    nRESET = 1'b0; nTS = 1'b1; TT0 = 1'b0; TT1 = 1'b0; RnW = 1'b1; SIZ = 2'b00; A = '0;
    nBG = 1'b0; nTA = 1'b1; ACK_TOG = 1'b0; PCI_ERR = 1'b0;
    repeat (2) @(negedge BCLK);
    chk("rst PCICYCLE", 0, PCICYCLE, 1'b0);
    chk("rst nBEN", 0, nBEN, 1'b1);
    chk("rst REQ_TOG", 0, REQ_TOG, 1'b0);
    chk("rst CMD", 0, CMD, 4'h0);
    chk("rst nCBE", 0, nCBE, 4'hF);
    chk("rst PADDR", 0, PADDR, 32'h0);
    chk("rst BURST", 0, BURST, 1'b0);
    chk("rst nTEA", 0, nTEA, 1'b1);
    nRESET = 1'b1;
    // Reset in the middle of a burst read.
    @(negedge BCLK);
    nTS = 1'b0; A = 32'hA000_0100; SIZ = 2'b11; RnW = 1'b1; TT0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge BCLK);
      @(negedge BCLK);
      nTS = 1'b1;
      nTA = k != 2;
    end
    nTA = 1'b1;
    chk("pre-rst PCICYCLE", 0, PCICYCLE, 1'b1);
    chk("pre-rst REQ_TOG", 0, REQ_TOG, 1'b1);
    nRESET = 1'b0;
    ACK_TOG = 1'b0;
    #1;
    chk("midrst PCICYCLE", 0, PCICYCLE, 1'b0);
    chk("midrst nBEN", 0, nBEN, 1'b1);
    chk("midrst REQ_TOG", 0, REQ_TOG, 1'b0);
    chk("midrst BURST", 0, BURST, 1'b0);
    @(negedge BCLK);
    nRESET = 1'b1;
    exp_req = 1'b0;
    // Directed transfers.
    run_xfer(32'hA000_0010, 2'b00, 1'b0, 64'h8, 4, 1'b0);
    run_xfer(32'hA000_0100, 2'b11, 1'b1, 64'h258, 3, 1'b0);
    run_xfer(32'hA800_0003, 2'b01, 1'b0, 64'h10, 3, 1'b0);
    run_xfer(32'hB000_0002, 2'b10, 1'b1, 64'h8, 5, 1'b0);
    run_xfer(32'hA000_0020, 2'b00, 1'b1, 64'h8, -1, 1'b0);
    run_xfer(32'hA000_0030, 2'b00, 1'b0, 64'h8, 5, 1'b1);
    run_xfer(32'hA000_0040, 2'b11, 1'b1, 64'h100, 3, 1'b1);
    // Bridge-register access: buffer enable only, released by the data-path's nTA.
    @(negedge BCLK);
    nTS = 1'b0; A = 32'hB800_0004; SIZ = 2'b00; RnW = 1'b1; TT0 = 1'b0;
    @(posedge BCLK);
    @(negedge BCLK);
    nTS = 1'b1;
    chk("reg nBEN", 0, nBEN, 1'b0);
    chk("reg PCICYCLE", 0, PCICYCLE, 1'b0);
    chk("reg REQ_TOG", 0, REQ_TOG, exp_req);
    @(posedge BCLK);
    @(negedge BCLK);
    chk("reg nBEN", 1, nBEN, 1'b0);
    chk("reg REQ_TOG", 1, REQ_TOG, exp_req);
    nTA = 1'b0;
    @(posedge BCLK);
    @(negedge BCLK);
    nTA = 1'b1;
    chk("reg nBEN", 2, nBEN, 1'b1);
    chk("reg PCICYCLE", 2, PCICYCLE, 1'b0);
    // Random transfers.
    for (int i = 0; i < 20; i++) begin
      sub = 2'($urandom_range(0, 2));
      siz = 2'($urandom);
      tgt = siz == 2'b11 ? 4 : 1;
      m = '0;
      e = $urandom_range(2, 5);
      for (int b = 0; b < tgt; b++) begin
        m[e] = 1'b1;
        e += $urandom_range(1, 3);
      end
      run_xfer({3'b101, sub, 27'($urandom)}, siz, 1'($urandom), m, $urandom_range(1, 20),
               $urandom_range(0, 4) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pci_cpu_cycle_ctrl.md
# pci_cpu_cycle_ctrl

CPU-side (BCLK-domain) cycle controller for the PCI bridge, directly upstream of the bridge data-path/FIFO stage. It decodes MC68040 transfers into the PCI window and drives `PCICYCLE` and `nBEN` to the data-path stage. It launches a request to the PCICLK-domain initiator over a toggle handshake, then counts `_TA` beats so that `PCICYCLE` is held for the whole transfer. It also generates byte enables, PCI command and a timeout `_TEA`.

## Interface
- `WIN`, default 3'b101: value of `A[31:29]` that selects the PCI window.
- `TIMEOUT`, default 255: BCLK cycles to wait for PCI acknowledge before `_TEA`; 8-bit counter.
- `BCLK` in 1: CPU bus clock. All state is on its rising edge.
- `nRESET` in 1: reset, asynchronous, active-low.
- `nTS` in 1: 68040 transfer start.
- `TT0`, `TT1` in 1: transfer type. `TT0 && !TT1` is a line (burst) transfer.
- `RnW` in 1: 1 = read.
- `SIZ` in 2: 00 long, 01 byte, 10 word, 11 line.
- `A` in 32: CPU address.
- `nBG` in 1: CPU bus grant. Low means the CPU owns the bus.
- `nTA` in 1: transfer acknowledge as seen on the bus, driven by the data-path stage.
- `ACK_TOG` in 1: toggles once per completed PCI transaction (PCICLK domain).
- `PCI_ERR` in 1: master/target abort flag. Valid when the `ACK_TOG` edge is seen.
- `PCICYCLE` out 1: bridge cycle active. Reset 0.
- `nBEN` out 1: bridge buffer enable, active-low. Reset 1.
- `REQ_TOG` out 1: toggles once per new PCI request. Reset 0.
- `CMD` out 4: PCI command, stable while `PCICYCLE`. Reset 4'h0.
- `nCBE` out 4: PCI byte enables, active-low. Reset 4'hF.
- `PADDR` out 32: latched address, `[1:0]` forced 00 for memory. Reset 0.
- `BURST` out 1: latched line-transfer flag. Reset 0.
- `nTEA` out 1: transfer error acknowledge. Driven low one cycle, otherwise 1. Reset 1.

## Operation
- Hit: `!nTS && !nBG && A[31:29]==WIN`. Subspace is `A[28:27]`: 00 memory, 01 I/O, 10 config, 11 bridge registers.
- Bridge-register hits assert `nBEN` only. No `REQ_TOG`, and `PCICYCLE` stays 0. The data-path stage terminates these cycles.
- `CMD` values:
  - Memory read: 0110. Memory read of a line: 1110.
  - Memory write: 0111.
  - I/O read/write: 0010/0011.
  - Config read/write: 1010/1011.
- `nCBE` is active-low, and bit n corresponds to address offset n (the data lanes are byte-swapped downstream).
  - Byte: `~(1<<A[1:0])`.
  - Word: 4'b1100 if `A[1]`=0, else 4'b0011.
  - Long or line: 4'b0000.
- States:
  - **IDLE**: outputs are at their reset values except `REQ_TOG`. On a hit to a non-register subspace:
    - latch `A`, `CMD`, `nCBE`, `BURST` into `PADDR`/`CMD`/`nCBE`/`BURST`;
    - set `PCICYCLE`=1 and `nBEN`=0;
    - go to REQ.
  - **REQ**: toggle `REQ_TOG`, clear the timeout counter, go to WAIT.
  - **WAIT**:
    - Count `nTA` low samples. The target is 4 if `BURST`, else 1.
    - Watch for an edge on the synchronised `ACK_TOG`.
    - When the ack is seen with `PCI_ERR`=1: pulse `nTEA`=0 for one cycle, go to DONE.
    - When the ack is seen and the beat count has reached its target: go to DONE.
    - When the counter reaches `TIMEOUT` with no ack: pulse `nTEA`, go to DONE.
  - **DONE**: `PCICYCLE`=0, `nBEN`=1, return to IDLE.
- Beat counter is 3 bits and saturates at 4. Extra `nTA` samples are ignored.
- Beats and ack may complete in either order. Both are required before DONE, except on error or timeout.
- `nTS` seen while not in IDLE is ignored. The 68040 cannot pipeline a second transfer before the final `_TA`.
- `nRESET` asserted mid-cycle: all outputs return to their reset values immediately. The ack synchroniser is cleared to the current `REQ_TOG` value (0).

## Timing
- `ACK_TOG` passes through a 2-flop synchroniser. An edge is detected when sync stage 2 differs from a 3rd register. Ack-edge latency is 3 BCLK.
- Hit sampled at edge n gives `PCICYCLE`/`nBEN` asserted after edge n. `REQ_TOG` flips after edge n+1.
- `nTA` is sampled on the rising BCLK edge. The data-path stage drives it on the falling edge.
- `PCICYCLE` stays high until the edge after both completion conditions hold. DONE lasts 1 cycle, so the minimum idle gap between bridge cycles is 1 BCLK.
- `nTEA` is low for exactly one BCLK, in the cycle that enters DONE. An ack and a timeout on the same edge count as the ack.
- `nCBE`, `CMD` and `PADDR` are stable from the `PCICYCLE` rise until it falls.

## Structure
- Shared package `pci_bridge_pkg` holds:
  - PCI command constants;
  - subspace codes;
  - state enum (IDLE, REQ, WAIT, DONE);
  - the `WIN` default.
- The byte-enable decode is a function in the package.
- One sub-module, `toggle_sync`: 2-flop synchroniser plus edge detect. It is reusable by the PCICLK side for `REQ_TOG`.

## Test plan
- Long write to 0xA000_0010 (memory, `SIZ`=00, `RnW`=0):
  - expect `CMD`=0111, `nCBE`=0000, `PADDR`=0xA000_0010 and one `REQ_TOG` flip;
  - after 1 `nTA` and an `ACK_TOG` flip, `PCICYCLE` falls 4 BCLK after the ack flip.
- Line read at 0xA000_0100:
  - `CMD`=1110, `BURST`=1;
  - ack arrives after 2 `nTA`s; `PCICYCLE` is held until the 4th `nTA`, then drops.
- Byte write at A=0xA800_0003 (I/O): `CMD`=0011, `nCBE`=0111. Word read at 0xB000_0002 (config): `CMD`=1010, `nCBE`=0011.
- Access at 0xB800_0004 (bridge registers): `nBEN`=0, `PCICYCLE`=0, no `REQ_TOG` flip.
- No ack: `nTEA` is low for exactly one cycle after 255 WAIT cycles, `PCICYCLE` falls the next edge. Ack with `PCI_ERR`=1: `nTEA` pulses once.
- `nRESET` low during WAIT of a burst: `PCICYCLE`=0, `nBEN`=1, `REQ_TOG`=0 immediately. A subsequent single write completes normally.
